shift_word_framer: RTL
======================

Name: shift_word_framer

Overview:
- Downstream consumer of the 6-bit left-shift register.
- Watches the register's parallel output and counts fresh shifts, aligned to a SYNC pulse.
- Every W shifts it captures the full W-bit word into a 2-entry buffer.
- Presents the buffered words on a valid/ready interface to the next stage.

Parameters:
- W, 6, word width; must equal the shift register width.
- DEPTH, 2, output buffer entries; fixed at 2, other values unsupported.

Ports:
- CLK  in  1  rising-edge clock, shared with the shift register.
- RST_N  in  1  asynchronous active-low reset.
- Q_IN  in  W  parallel output of the shift register.
- BIT_VLD  in  1  Q_IN holds a freshly shifted value this cycle, i.e. the shift happened at the previous edge.
- SYNC  in  1  single-cycle frame-alignment pulse.
- DATA_OUT  out  W  head word of the buffer.
- VALID_OUT  out  1  buffer not empty.
- READY_IN  in  1  consumer accepts DATA_OUT this cycle.
- OVERFLOW  out  1  sticky flag: a word was dropped.
- LOCKED  out  1  FSM is in COLLECT.

Behaviour:
- Reset (async, RST_N=0):
  - FSM=HUNT, cnt=0, buffer empty.
  - VALID_OUT=0, DATA_OUT=0, OVERFLOW=0, LOCKED=0.
  - Reset mid-frame discards the partial count and all buffered words.
- FSM states: HUNT, COLLECT.
  - HUNT: BIT_VLD is ignored. SYNC moves the FSM to COLLECT.
  - COLLECT: SYNC realigns the frame; the FSM stays in COLLECT. No other exit except reset.
- SYNC, in either state:
  - With BIT_VLD=0: cnt<=0.
  - With BIT_VLD=1: cnt<=1, and that bit is the first bit of the frame.
  - SYNC also clears OVERFLOW.
  - SYNC never pushes a word, even if cnt==W-1.
- Counter in COLLECT, no SYNC, BIT_VLD=1:
  - cnt<W-1: cnt<=cnt+1.
  - cnt==W-1: push Q_IN, then cnt<=0 (wrap).
- Counter width is $clog2(W) bits; it never exceeds W-1.
- Pop: when VALID_OUT && READY_IN at an edge, the head is removed.
  - DATA_OUT is 0 when the buffer is empty.
- Push latency: word captured at edge N gives VALID_OUT=1 and DATA_OUT=word in the cycle after edge N. There is no combinational path from Q_IN to DATA_OUT.
- Full (2 entries):
  - Push with no pop: the incoming word is dropped, buffer unchanged, OVERFLOW<=1.
  - Push with pop in the same cycle: both happen. The buffer stays full and keeps order.
- Empty: push and pop in the same cycle cannot occur because VALID_OUT=0. The push lands and VALID_OUT rises next cycle.
- Ordering: strict FIFO.
- READY_IN while VALID_OUT=0 has no effect.
- LOCKED = (state==COLLECT), registered.

Optional Feature:
- Macro: FRAMER_PARITY_EN.
- Defined:
  - Extra output PARITY_OUT (1 bit) = even parity (XOR reduction) of the head word.
  - Stored per entry at push time; reset value 0; 0 when the buffer is empty.
- Undefined: the port and its storage are absent. All other behaviour is identical.

Decomposition:
- Package shift_framer_pkg holds:
  - FRAMER_W = 6 and FRAMER_DEPTH = 2 localparams.
  - state enum {HUNT, COLLECT}.
  - cnt_t typedef, sized $clog2(FRAMER_W).
- One sub-module: framer_fifo2.
  - 2-entry register FIFO with push/pop/full/empty flags and async active-low reset.
  - Data width is W, or W+1 when FRAMER_PARITY_EN is defined.
- The top level holds the FSM, counter and overflow logic.

Test Plan:
- Reset mid-frame: assert RST_N=0 after 3 bits -> next cycle VALID_OUT=0, LOCKED=0, OVERFLOW=0; after release, 6 BIT_VLD pulses without SYNC -> no word.
- SYNC (BIT_VLD=0), then 6 BIT_VLD cycles with Q_IN ending at 6'b101101, READY_IN=1 -> VALID_OUT=1 for one cycle, DATA_OUT=6'b101101.
- SYNC with BIT_VLD=1, then 5 more BIT_VLD, final Q_IN=6'b111111 -> one word 6'b111111, captured after 6 total bits (not 7).
- READY_IN=0, 3 frames (6'h01, 6'h02, 6'h03) -> buffer holds 6'h01, 6'h02; OVERFLOW=1; draining gives 6'h01 then 6'h02; SYNC clears OVERFLOW.
- Full buffer, 3rd push coincides with pop -> no overflow; output sequence 6'h01, 6'h02, 6'h03.
- FRAMER_PARITY_EN defined, word 6'b000111 -> PARITY_OUT=1; word 6'b000011 -> PARITY_OUT=0.

Source files
------------

// File: rtl/shift_framer_pkg.sv
// Shared types and sizes for the shift-register word framer.
// FRAMER_PARITY_EN widens each buffer entry by one stored parity bit.
package shift_framer_pkg;

  localparam int FRAMER_W     = 6;
  localparam int FRAMER_DEPTH = 2;
  localparam int CNT_W        = $clog2(FRAMER_W);

`ifdef FRAMER_PARITY_EN
  localparam int FIFO_W = FRAMER_W + 1;
`else
  localparam int FIFO_W = FRAMER_W;
`endif

  typedef enum logic {HUNT, COLLECT} state_e;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/framer_fifo2.sv
// Two-entry register FIFO; entry 0 is always the head.
// A push into a full FIFO is ignored unless a pop happens in the same cycle.
module framer_fifo2
  import shift_framer_pkg::*;
#(
  parameter int DW = FIFO_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    rem;
  logic          do_pop, do_push;

  assign empty = (cnt_q == 2'd0);
  assign full  = (cnt_q == 2'd2);
  assign dout  = empty ? '0 : mem_q[0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mem_d   = mem_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rem     = cnt_q - {1'b0, do_pop};
    if (do_pop) mem_d[0] = mem_q[1];
    if (do_push) mem_d[rem[0]] = din;
    cnt_d = rem + {1'b0, do_push};
  end

  // NOTE: the storage is reset too; it is tiny and keeps DATA_OUT deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state.
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/shift_word_framer.sv
// Frames W fresh shifts of an upstream shift register into words, aligned by SYNC.
// Define FRAMER_PARITY_EN to add PARITY_OUT (even parity of the head word).
module shift_word_framer
  import shift_framer_pkg::*;
#(
  parameter int W     = FRAMER_W,
  parameter int DEPTH = FRAMER_DEPTH
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] Q_IN,
  input  logic         BIT_VLD,
  input  logic         SYNC,
  output logic [W-1:0] DATA_OUT,
  output logic         VALID_OUT,
  input  logic         READY_IN,
  output logic         OVERFLOW,
`ifdef FRAMER_PARITY_EN
  output logic         PARITY_OUT,
`endif
  output logic         LOCKED
);

  localparam cnt_t LAST = cnt_t'(W - 1);

  state_e          state_q, state_d;
  cnt_t            cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            push, pop, full, empty;
  logic [FIFO_W-1:0] fifo_din, fifo_dout;

  assign pop       = !empty && READY_IN;
  assign VALID_OUT = !empty;
  assign OVERFLOW  = ovf_q;
  assign LOCKED    = (state_q == COLLECT);
  assign DATA_OUT  = fifo_dout[W-1:0];

`ifdef FRAMER_PARITY_EN
  assign fifo_din   = {^Q_IN, Q_IN};
  assign PARITY_OUT = fifo_dout[W];
`else
  assign fifo_din   = Q_IN;
`endif

  // SYNC takes priority over counting and never produces a word itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    if (SYNC) begin
      state_d = COLLECT;
      cnt_d   = BIT_VLD ? cnt_t'(1) : cnt_t'(0);
      ovf_d   = 1'b0;
    end else if (state_q == COLLECT && BIT_VLD) begin
      if (cnt_q == LAST) begin
        push  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  framer_fifo2 #(.DW(FIFO_W)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

endmodule
